// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer arbiter.
//   FB_ADDR_W / FB_DATA_W : frame buffer address ({row, col}) and pixel ({R, G, B}) widths
//   fb_state_t            : arbiter FSM state encoding
//   fb_wentry_t           : one posted host write, {addr, data}
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 24;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_DRAIN = 2'd1,
    FSM_RD    = 2'd2
  } fb_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wentry_t;

endpackage

// File: rtl/fb_wfifo.sv
// Small synchronous FIFO holding posted host writes.
//   clk, reset_n      : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   : enqueue one entry (ignored when full)
//   pop               : dequeue the head entry (ignored when empty)
//   head              : current head entry, combinational, valid when !empty
//   full, empty       : derived from the occupancy count
//   level             : number of occupied entries
module fb_wfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == LVL_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign level   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is read combinationally: the drain write goes out on the
  // frame buffer port in the same cycle it is popped.
  assign head = mem_reg[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame buffer arbiter shared between the VGA refresh reader and
// a host port.
//   clk, reset_n                 : pixel clock, synchronous active-low reset
//   vc_request, vc_*_address     : VGA read request, always served the same cycle
//   vc_read_data                 : pixel for the VGA (fb_rdata passed through)
//   host_req/we/addr/wdata       : host command, accepted on host_req && host_ready
//   host_ready                   : command can be accepted this cycle
//   host_rvalid, host_rdata      : one-cycle read return pulse, data held until next return
//   fb_en/we/addr/wdata, fb_rdata: frame buffer port (asynchronous read data)
//   wfifo_level                  : occupancy of the posted write FIFO
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int WFIFO_DEPTH = 4,
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  localparam int LVL_W      = $clog2(WFIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vc_request,
  input  logic [7:0]        vc_col_address,
  input  logic [7:0]        vc_row_address,
  output logic [DATA_W-1:0] vc_read_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              fb_en,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [LVL_W-1:0]  wfifo_level
);

  fb_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic              host_rvalid_reg;
  logic [DATA_W-1:0] host_rdata_reg;

  fb_wentry_t        wf_in;
  fb_wentry_t        wf_head;
  logic              wf_push;
  logic              wf_pop;
  logic              wf_full;
  logic              wf_empty;
  logic              rd_grant;
  logic              drained;

  assign wf_in = '{addr: host_addr, data: host_wdata};

  fb_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH ($bits(fb_wentry_t))
  ) u_wfifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wf_push),
    .push_data (wf_in),
    .pop       (wf_pop),
    .head      (wf_head),
    .full      (wf_full),
    .empty     (wf_empty),
    .level     (wfifo_level)
  );

  assign vc_read_data = fb_rdata;
  assign host_rvalid  = host_rvalid_reg;
  assign host_rdata   = host_rdata_reg;

  // FIFO is empty at the end of this cycle once this cycle's pop is counted.
  assign drained = (wfifo_level == LVL_W'(wf_pop));

  // Port mux: VGA first, then a pending host read, then the write drain.
  always_comb begin
    fb_en    = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    wf_pop   = 1'b0;
    rd_grant = 1'b0;
    if (vc_request) begin
      fb_en   = 1'b1;
      fb_addr = {vc_row_address, vc_col_address};
    end else if (state_reg == FSM_RD) begin
      fb_en    = 1'b1;
      fb_addr  = rd_addr_reg;
      rd_grant = 1'b1;
    end else if (!wf_empty) begin
      fb_en    = 1'b1;
      fb_we    = 1'b1;
      fb_addr  = wf_head.addr;
      fb_wdata = wf_head.data;
      wf_pop   = 1'b1;
    end
  end

  // A read waits in DRAIN until every earlier posted write has reached
  // memory, so it always observes the latest write to its address.
  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    host_ready   = 1'b0;
    wf_push      = 1'b0;
    case (state_reg)
      FSM_IDLE: begin
        host_ready = host_we ? !wf_full : 1'b1;
        if (host_req && host_ready) begin
          if (host_we) begin
            wf_push = 1'b1;
          end else begin
            rd_addr_next = host_addr;
            state_next   = drained ? FSM_RD : FSM_DRAIN;
          end
        end
      end
      FSM_DRAIN: begin
        if (drained) begin
          state_next = FSM_RD;
        end
      end
      FSM_RD: begin
        if (rd_grant) begin
          state_next = FSM_IDLE;
        end
      end
      default: state_next = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= FSM_IDLE;
      rd_addr_reg     <= '0;
      host_rvalid_reg <= 1'b0;
      host_rdata_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      rd_addr_reg     <= rd_addr_next;
      host_rvalid_reg <= rd_grant;
      if (rd_grant) begin
        host_rdata_reg <= fb_rdata;
      end
    end
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Owns the single port of the 256x256x24 frame buffer and shares it between the VGA refresh reader and a host drawing/CPU port.
- The VGA refresh reader has absolute priority and is serviced in the same cycle it requests.
- Host writes are posted into a small FIFO and drained in cycles the VGA does not use.
- Host reads are ordered after all earlier posted writes and return data with a one-cycle valid pulse.

Parameters:
- WFIFO_DEPTH, 4, number of posted host write entries (power of 2, ≥2).
- ADDR_W, 16, frame buffer address width; address is {row[7:0], col[7:0]}.
- DATA_W, 24, pixel width {R[7:0], G[7:0], B[7:0]}.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- vc_request  in  1  VGA read request, active-high.
- vc_col_address  in  8  VGA column address.
- vc_row_address  in  8  VGA row address.
- vc_read_data  out  24  pixel returned to VGA, same cycle as vc_request.
- host_req  in  1  host command valid.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  16  host address {row, col}.
- host_wdata  in  24  host write data.
- host_ready  out  1  command accepted when host_req && host_ready at a clk edge.
- host_rvalid  out  1  one-cycle pulse; host_rdata is valid.
- host_rdata  out  24  read return data, held until the next read return.
- fb_en  out  1  frame buffer access enable.
- fb_we  out  1  frame buffer write enable.
- fb_addr  out  16  frame buffer address.
- fb_wdata  out  24  frame buffer write data.
- fb_rdata  in  24  frame buffer combinational (asynchronous) read data.
- wfifo_level  out  clog2(WFIFO_DEPTH)+1  number of occupied write FIFO entries.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, FIFO emptied (pending writes discarded), host_rvalid=0, host_rdata=0, wfifo_level=0. A read in flight when reset is asserted is dropped and never returns host_rvalid.
- Port mux, combinational, priority order each cycle:
  - (1) vc_request=1: fb_en=1, fb_we=0, fb_addr={vc_row_address, vc_col_address}.
  - (2) state=RD: host read; fb_en=1, fb_we=0, fb_addr=rd_addr_r.
  - (3) FIFO not empty: pop head; fb_en=1, fb_we=1, fb_addr/fb_wdata = head entry.
  - (4) otherwise fb_en=0, fb_we=0, fb_addr=0, fb_wdata=0.
- vc_read_data = fb_rdata combinationally, with zero latency; it is undefined when vc_request=0. VGA service is never delayed or stalled.
- FSM states: IDLE, DRAIN, RD.
  - IDLE: host_ready = host_we ? !wfifo_full : 1.
    - Write accept: push {host_addr, host_wdata}.
    - Read accept: latch rd_addr_r. Next state is DRAIN if, after this cycle's pop, the FIFO is still non-empty; otherwise RD.
  - DRAIN: host_ready=0. Go to RD in the cycle after the FIFO reaches empty.
  - RD: host_ready=0. If vc_request=1, stay in RD. Otherwise the read is granted: host_rdata <= fb_rdata, host_rvalid=1 on the next cycle, next state IDLE.
- Read latency is at least 2 cycles from accept (accept → RD → rvalid). It grows by FIFO drain cycles plus any VGA-occupied cycles.
- Ordering guarantees:
  - A read returns the value of the most recent prior accepted write to the same address.
  - Writes reach memory in acceptance order.
- Simultaneous push and pop in one cycle: level is unchanged. A push into a full FIFO is impossible because host_ready=0.
- Write latency: an accepted write is earliest in memory on the following cycle.
- host_rvalid pulses exactly once per accepted read. It can coincide with host_ready=1, so back-to-back reads are allowed.
- Starvation: the host can wait for the full VGA active span (256 consecutive cycles). There is no timeout; the host must tolerate this.
- Pointers wrap modulo WFIFO_DEPTH. Full/empty are derived from the occupancy count.

Decomposition:
- Shared package fb_pkg holds:
  - constants FB_ADDR_W=16 and FB_DATA_W=24;
  - state encoding FSM_IDLE / FSM_DRAIN / FSM_RD;
  - the write entry layout {addr, data}.
- One sub-module, fb_wfifo: a synchronous FIFO with push, pop, head, full, empty and level. The arbiter FSM and port mux stay in fb_arbiter.

Test Plan:
- Reset, then idle → host_ready=1, fb_en=0, wfifo_level=0, host_rvalid=0.
- Write (addr 0x0102, 0xAA5500) with vc_request=0 → next cycle fb_we=1, fb_addr=0x0102, fb_wdata=0xAA5500; level returns to 0.
- vc_request held high for 256 cycles while the host posts 5 writes → 4 accepted, host_ready=0 on the 5th. fb_we=0 throughout the VGA span; the FIFO drains in order once vc_request drops.
- Write 0x123456 to 0x0A0B, then immediately read 0x0A0B, with VGA requesting every other cycle → host_rvalid once, host_rdata=0x123456. The read grant never coincides with vc_request=1.
- Continuous vc_request with varying addresses → fb_addr tracks {row, col} every cycle and vc_read_data == fb_rdata in the same cycle.
- reset_n low while in DRAIN with 3 writes queued → after reset level=0, no host_rvalid, and none of the 3 writes appears on the fb port.
